// File: rtl/pu_msp430_mpy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pu_msp430_mpy_pkg
//  Description : Shared constants for the hardware multiplier register map
//                and the MAC sequencer state type. The offsets are the byte
//                offsets that the multiplier itself decodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package pu_msp430_mpy_pkg;

    // Default byte base address of the multiplier block.
    localparam logic [14:0] c_MPY_BASE_DFLT = 15'h0130;

    // Byte offsets from the multiplier base.
    localparam logic [3:0] c_OFS_OP1_MPY  = 4'h0;
    localparam logic [3:0] c_OFS_OP1_MPYS = 4'h2;
    localparam logic [3:0] c_OFS_OP1_MAC  = 4'h4;
    localparam logic [3:0] c_OFS_OP1_MACS = 4'h6;
    localparam logic [3:0] c_OFS_OP2      = 4'h8;
    localparam logic [3:0] c_OFS_RESLO    = 4'hA;
    localparam logic [3:0] c_OFS_RESHI    = 4'hC;
    localparam logic [3:0] c_OFS_SUMEXT   = 4'hE;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_OP1 = 3'd1,
        S_WR_OP2 = 3'd2,
        S_GAP    = 3'd3,
        S_RD_LO  = 3'd4,
        S_RD_HI  = 3'd5,
        S_RD_EXT = 3'd6,
        S_RESP   = 3'd7
    } mac_state_t;

endpackage
`default_nettype wire

// File: rtl/pu_msp430_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pu_msp430_mac_sequencer
//  Description : Peripheral-bus initiator that runs the hardware multiplier
//                as a MAC engine. Takes a stream of operand pairs, writes
//                OP1_MPY(S)/OP1_MAC(S) and OP2 for each, then reads RESLO,
//                RESHI and SUMEXT back into one 48-bit result.
//  Ports       : mclk, puc_rst_n          - clock, async active-low reset
//                cmd_valid/ready/op1/op2/last/signed - operand pair stream
//                res_valid/ready/data/count - job result and pair count
//                busy                     - job in progress
//                bus_req, bus_gnt         - arbiter request / grant
//                per_addr/din/en/we/dout  - peripheral bus master interface
//  Revision    : 1.0 - initial release
// ============================================================================
module pu_msp430_mac_sequencer
    import pu_msp430_mpy_pkg::*;
#(
    parameter logic [14:0] MPY_BASE = c_MPY_BASE_DFLT,
    parameter int          GAP_CYC  = 2,
    parameter int          CNT_W    = 8
) (
    input  logic             mclk,
    input  logic             puc_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_op1,
    input  logic [15:0]      cmd_op2,
    input  logic             cmd_last,
    input  logic             cmd_signed,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic [CNT_W-1:0] res_count,
    output logic             busy,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [13:0]      per_addr,
    output logic [15:0]      per_din,
    output logic             per_en,
    output logic [1:0]       per_we,
    input  logic [15:0]      per_dout
);

    // The GAP state always lasts at least one cycle so that a following pair
    // can be offered; with GAP_CYC of 0 or 1 that single cycle is the final one.
    localparam int                 c_GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = (GAP_CYC > 0) ? c_GAP_W'(GAP_CYC - 1) : '0;
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    mac_state_t         r_state;
    mac_state_t         w_state_nxt;
    logic [15:0]        r_op1;
    logic [15:0]        r_op2;
    logic               r_last;
    logic               r_signed;
    logic               r_first;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [47:0]        r_res;

    logic               w_gap_done;
    logic               w_ready;
    logic               w_access;
    logic               w_write;
    logic [3:0]         w_ofs;
    logic [15:0]        w_din;
    logic               w_cmd_hs;

    assign w_gap_done = (r_gap_cnt == '0);
    assign cmd_ready  = w_ready & puc_rst_n;
    assign w_cmd_hs   = cmd_valid & cmd_ready;

    // ------------------------------------------------------------------------
    // Next-state and per-state bus outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_access    = 1'b0;
        w_write     = 1'b0;
        w_ofs       = 4'h0;
        w_din       = 16'h0000;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (cmd_valid) w_state_nxt = S_WR_OP1;
            end
            S_WR_OP1: begin
                w_access = 1'b1;
                w_write  = 1'b1;
                w_din    = r_op1;
                // The first pair uses MPY/MPYS so any stale accumulator is cleared.
                if (r_first) w_ofs = r_signed ? c_OFS_OP1_MPYS : c_OFS_OP1_MPY;
                else         w_ofs = r_signed ? c_OFS_OP1_MACS : c_OFS_OP1_MAC;
                if (bus_gnt) w_state_nxt = S_WR_OP2;
            end
            S_WR_OP2: begin
                w_access = 1'b1;
                w_write  = 1'b1;
                w_din    = r_op2;
                w_ofs    = c_OFS_OP2;
                if (bus_gnt) w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (w_gap_done) begin
                    if (r_last) begin
                        w_state_nxt = S_RD_LO;
                    end else begin
                        w_ready = 1'b1;
                        if (cmd_valid) w_state_nxt = S_WR_OP1;
                    end
                end
            end
            S_RD_LO: begin
                w_access = 1'b1;
                w_ofs    = c_OFS_RESLO;
                if (bus_gnt) w_state_nxt = S_RD_HI;
            end
            S_RD_HI: begin
                w_access = 1'b1;
                w_ofs    = c_OFS_RESHI;
                if (bus_gnt) w_state_nxt = S_RD_EXT;
            end
            S_RD_EXT: begin
                w_access = 1'b1;
                w_ofs    = c_OFS_SUMEXT;
                if (bus_gnt) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (res_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus_req   = w_access;
    assign per_en    = w_access & bus_gnt;
    assign per_we    = (w_write & bus_gnt) ? 2'b11 : 2'b00;
    assign per_addr  = w_access ? 14'((MPY_BASE + {11'b0, w_ofs}) >> 1) : 14'h0000;
    assign per_din   = w_din;
    assign busy      = (r_state != S_IDLE);
    assign res_valid = (r_state == S_RESP);
    assign res_data  = r_res;
    assign res_count = r_cnt;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------------
    // Operand capture, pair counter, gap counter and result assembly
    // ------------------------------------------------------------------------
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_op1     <= 16'h0000;
            r_op2     <= 16'h0000;
            r_last    <= 1'b0;
            r_signed  <= 1'b0;
            r_first   <= 1'b0;
            r_gap_cnt <= '0;
            r_cnt     <= '0;
            r_res     <= 48'h0;
        end else begin
            if (w_cmd_hs) begin
                r_op1  <= cmd_op1;
                r_op2  <= cmd_op2;
                r_last <= cmd_last;
                if (r_state == S_IDLE) begin
                    // Signedness is a job property, fixed by the first pair.
                    r_signed <= cmd_signed;
                    r_first  <= 1'b1;
                    r_cnt    <= CNT_W'(1);
                end else begin
                    r_first <= 1'b0;
                    if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            if ((r_state == S_WR_OP2) && bus_gnt)
                r_gap_cnt <= c_GAP_LOAD;
            else if ((r_state == S_GAP) && !w_gap_done)
                r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);

            if (bus_gnt) begin
                case (r_state)
                    S_RD_LO:  r_res[15:0]  <= per_dout;
                    S_RD_HI:  r_res[31:16] <= per_dout;
                    S_RD_EXT: r_res[47:32] <= per_dout;
                    default:  ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pu_msp430_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pu_msp430_mac_sequencer
//  Description : Self-checking bench for the MAC sequencer. A register-level
//                model of the hardware multiplier answers the bus; job results
//                are predicted from the operand list with plain arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pu_msp430_mac_sequencer;

    localparam int GAP_CYC = 2;
    localparam int CNT_W   = 8;

    localparam logic [13:0] A_MPY  = 14'h098;
    localparam logic [13:0] A_MPYS = 14'h099;
    localparam logic [13:0] A_MAC  = 14'h09A;
    localparam logic [13:0] A_MACS = 14'h09B;
    localparam logic [13:0] A_OP2  = 14'h09C;
    localparam logic [13:0] A_LO   = 14'h09D;
    localparam logic [13:0] A_HI   = 14'h09E;
    localparam logic [13:0] A_EXT  = 14'h09F;

    logic             mclk = 1'b0;
    logic             puc_rst_n;
    logic             cmd_valid, cmd_ready, cmd_last, cmd_signed;
    logic [15:0]      cmd_op1, cmd_op2;
    logic             res_valid, res_ready;
    logic [47:0]      res_data;
    logic [CNT_W-1:0] res_count;
    logic             busy, bus_req, bus_gnt;
    logic [13:0]      per_addr;
    logic [15:0]      per_din, per_dout;
    logic             per_en;
    logic [1:0]       per_we;

    pu_msp430_mac_sequencer #(
        .MPY_BASE (15'h0130),
        .GAP_CYC  (GAP_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .mclk       (mclk),
        .puc_rst_n  (puc_rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op1    (cmd_op1),
        .cmd_op2    (cmd_op2),
        .cmd_last   (cmd_last),
        .cmd_signed (cmd_signed),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_count  (res_count),
        .busy       (busy),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .per_addr   (per_addr),
        .per_din    (per_din),
        .per_en     (per_en),
        .per_we     (per_we),
        .per_dout   (per_dout)
    );

    always #5 mclk = ~mclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Hardware multiplier model and bus monitor
    // ------------------------------------------------------------------------
    logic [15:0] m_op1 = 16'h0, m_lo = 16'h0, m_hi = 16'h0, m_ext = 16'h0;
    logic [1:0]  m_mode = 2'd0;
    int          cyc = 0;
    int          proto_err = 0;
    int          stall_seen = 0;
    int          stall_bad = 0;
    logic [13:0] log_addr[$];
    logic [15:0] log_data[$];
    logic [1:0]  log_we[$];
    int          log_cyc[$];

    function automatic logic [47:0] mpy_result(input logic [1:0] mode, input logic [15:0] a,
                                               input logic [15:0] b, input logic [31:0] acc);
        longint up, sp, s;
        logic [31:0] r;
        up = longint'(a) * longint'(b);
        sp = longint'($signed(a)) * longint'($signed(b));
        case (mode)
            2'd0: return {16'h0000, up[31:0]};
            2'd1: begin r = sp[31:0]; return {(r[31] ? 16'hFFFF : 16'h0000), r}; end
            2'd2: begin s = longint'(acc) + up; return {(s[32] ? 16'h0001 : 16'h0000), s[31:0]}; end
            default: begin
                s = longint'($signed(acc)) + sp; r = s[31:0];
                return {(r[31] ? 16'hFFFF : 16'h0000), r};
            end
        endcase
    endfunction

    always_comb begin
        case (per_addr)
            A_LO:    per_dout = m_lo;
            A_HI:    per_dout = m_hi;
            A_EXT:   per_dout = m_ext;
            default: per_dout = 16'h0000;
        endcase
    end

    always @(posedge mclk) cyc <= cyc + 1;

    always @(negedge mclk) begin
        if (per_en !== (bus_req & bus_gnt)) proto_err <= proto_err + 1;
        if (per_addr == A_OP2 && !bus_gnt) begin
            stall_seen <= stall_seen + 1;
            if (!bus_req || per_en) stall_bad <= stall_bad + 1;
        end
        if (per_en) begin
            log_addr.push_back(per_addr);
            log_data.push_back(per_we == 2'b11 ? per_din : per_dout);
            log_we.push_back(per_we);
            log_cyc.push_back(cyc);
            if (per_we == 2'b11) begin
                case (per_addr)
                    A_MPY:  begin m_op1 <= per_din; m_mode <= 2'd0; end
                    A_MPYS: begin m_op1 <= per_din; m_mode <= 2'd1; end
                    A_MAC:  begin m_op1 <= per_din; m_mode <= 2'd2; end
                    A_MACS: begin m_op1 <= per_din; m_mode <= 2'd3; end
                    A_OP2:  {m_ext, m_hi, m_lo} <= mpy_result(m_mode, m_op1, per_din, {m_hi, m_lo});
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Grant driver: tied high or random, with an optional stall on OP2
    // ------------------------------------------------------------------------
    int gnt_mode   = 0;
    int stall_left = 0;

    initial begin
        bus_gnt = 1'b0;
        forever begin
            @(posedge mclk);
            #1;
            if (stall_left > 0 && bus_req && per_addr == A_OP2) begin
                bus_gnt = 1'b0;
                stall_left--;
            end else begin
                bus_gnt = (gnt_mode == 0) ? 1'b1 : ($urandom_range(99, 0) < 65);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reference: job result from the operand list
    // ------------------------------------------------------------------------
    logic [15:0] q_op1[$];
    logic [15:0] q_op2[$];
    logic [47:0] last_res;
    int          last_base;

    function automatic logic [47:0] job_expect(input bit sgn);
        longint sum, prev, p;
        logic [31:0] lo;
        logic [63:0] t;
        logic [15:0] ext;
        int n;
        n = q_op1.size(); sum = 0; prev = 0; p = 0;
        for (int i = 0; i < n; i++) begin
            if (sgn) p = longint'($signed(q_op1[i])) * longint'($signed(q_op2[i]));
            else     p = longint'(q_op1[i]) * longint'(q_op2[i]);
            if (i == n - 1) prev = sum;
            sum = sum + p;
        end
        lo = sum[31:0];
        if (sgn) begin
            ext = lo[31] ? 16'hFFFF : 16'h0000;
        end else begin
            // SUMEXT only reflects the carry of the final accumulation.
            t   = {32'h0, prev[31:0]} + {32'h0, p[31:0]};
            ext = (n > 1 && t[32]) ? 16'h0001 : 16'h0000;
        end
        return {ext, lo};
    endfunction

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(5, 0))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic run_job(input bit sgn, input int idle_max, input int rdy_hold);
        int n, na, bad, pe0;
        bit ok;
        logic [47:0] held, exp_res;
        logic [13:0] a1;
        n = q_op1.size();
        pe0 = proto_err;
        @(posedge mclk); #1;
        last_base = log_addr.size();
        exp_res = job_expect(sgn);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(idle_max, 0)) begin
                cmd_valid = 1'b0; cmd_op1 = 16'($urandom); cmd_op2 = 16'($urandom);
                @(posedge mclk); #1;
            end
            cmd_valid  = 1'b1;
            cmd_op1    = q_op1[i];
            cmd_op2    = q_op2[i];
            cmd_last   = (i == n - 1);
            cmd_signed = (i == 0) ? sgn : 1'($urandom);
            ok = 0;
            for (int w = 0; w < 200; w++) begin
                @(negedge mclk);
                if (cmd_ready) begin ok = 1; break; end
            end
            if (!ok) begin chk("handshake_timeout", 0, 1); cmd_valid = 1'b0; return; end
            @(posedge mclk); #1;
            cmd_valid = 1'b0;
            cmd_op1 = 16'($urandom);
        end
        ok = 0;
        for (int w = 0; w < 500; w++) begin
            @(negedge mclk);
            if (res_valid) begin ok = 1; break; end
        end
        if (!ok) begin chk("result_timeout", 0, 1); return; end
        held = res_data;
        bad = 0;
        for (int k = 0; k < rdy_hold; k++) begin
            if (!res_valid || res_data !== held || cmd_ready) bad++;
            @(negedge mclk);
        end
        if (rdy_hold > 0) chk("resp_hold_stable", bad, 0);
        last_res = res_data;
        chk("res_data", res_data, exp_res);
        chk("res_count", res_count, (n > 255) ? 255 : n);
        res_ready = 1'b1;
        @(posedge mclk); #1;
        res_ready = 1'b0;
        @(negedge mclk);
        chk("idle_after_resp", {busy, res_valid, cmd_ready}, 3'b001);
        chk("bus_protocol", proto_err - pe0, 0);
        na = log_addr.size() - last_base;
        chk("n_access", na, 2 * n + 3);
        if (na == 2 * n + 3) begin
            bad = 0;
            for (int i = 0; i < n; i++) begin
                a1 = (i == 0) ? (sgn ? A_MPYS : A_MPY) : (sgn ? A_MACS : A_MAC);
                if (log_addr[last_base+2*i] != a1 || log_data[last_base+2*i] != q_op1[i] ||
                    log_we[last_base+2*i] != 2'b11) bad++;
                if (log_addr[last_base+2*i+1] != A_OP2 || log_data[last_base+2*i+1] != q_op2[i] ||
                    log_we[last_base+2*i+1] != 2'b11) bad++;
                if (log_cyc[last_base+2*i+2] - log_cyc[last_base+2*i+1] < GAP_CYC + 1) bad++;
            end
            if (log_addr[last_base+2*n] != A_LO || log_addr[last_base+2*n+1] != A_HI ||
                log_addr[last_base+2*n+2] != A_EXT) bad++;
            for (int r = 0; r < 3; r++) if (log_we[last_base+2*n+r] != 2'b00) bad++;
            chk("access_sequence", bad, 0);
        end
    endtask

    task automatic set_pair(input logic [15:0] a, input logic [15:0] b);
        q_op1.push_back(a);
        q_op2.push_back(b);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int s0, b0, n;
        bit ok, sg;
        puc_rst_n = 1'b0; cmd_valid = 1'b0; cmd_op1 = 16'h0; cmd_op2 = 16'h0;
        cmd_last = 1'b0; cmd_signed = 1'b0; res_ready = 1'b0;
        #12;
        chk("reset_outputs", {cmd_ready, res_valid, res_data, res_count, busy, bus_req,
                              per_addr, per_din, per_en, per_we}, 0);
        @(posedge mclk); #1;
        puc_rst_n = 1'b1;
        @(negedge mclk);
        chk("idle_ready", {cmd_ready, busy, bus_req}, 3'b100);

        // Unsigned 3*5
        gnt_mode = 0;
        q_op1.delete(); q_op2.delete(); set_pair(16'd3, 16'd5);
        run_job(1'b0, 0, 0);
        chk("dir_3x5_res", last_res, 48'h0000_0000_000F);
        chk("dir_3x5_addr", {log_addr[last_base], log_addr[last_base+1]}, {A_MPY, A_OP2});

        // Signed 0xFFFF*2
        q_op1.delete(); q_op2.delete(); set_pair(16'hFFFF, 16'h0002);
        run_job(1'b1, 0, 0);
        chk("dir_signed_res", last_res, 48'hFFFF_FFFF_FFFE);
        chk("dir_signed_addr", log_addr[last_base], A_MPYS);

        // Unsigned MAC 0xFFFF*0xFFFF twice
        q_op1.delete(); q_op2.delete(); set_pair(16'hFFFF, 16'hFFFF); set_pair(16'hFFFF, 16'hFFFF);
        run_job(1'b0, 0, 0);
        chk("dir_mac_res", last_res, 48'h0001_FFFC_0002);
        chk("dir_mac_addr", log_addr[last_base+2], A_MAC);

        // Grant withheld for 5 cycles during the OP2 write
        q_op1.delete(); q_op2.delete(); set_pair(16'd1234, 16'd5678);
        s0 = stall_seen; b0 = stall_bad; stall_left = 5;
        run_job(1'b0, 0, 0);
        chk("stall_cycles", stall_seen - s0, 5);
        chk("stall_req_held", stall_bad - b0, 0);
        n = 0;
        for (int i = last_base; i < log_addr.size(); i++) if (log_addr[i] == A_OP2) n++;
        chk("stall_one_op2", n, 1);

        // Result consumer stalls for 10 cycles
        q_op1.delete(); q_op2.delete(); set_pair(16'h1357, 16'h2468); set_pair(16'h8000, 16'h0003);
        run_job(1'b1, 1, 10);

        // Asynchronous reset in the middle of RD_HI
        @(posedge mclk); #1;
        cmd_valid = 1'b1; cmd_op1 = 16'd7; cmd_op2 = 16'd9; cmd_last = 1'b1; cmd_signed = 1'b0;
        ok = 0;
        for (int w = 0; w < 20; w++) begin @(negedge mclk); if (cmd_ready) begin ok = 1; break; end end
        @(posedge mclk); #1;
        cmd_valid = 1'b0;
        if (ok) begin
            ok = 0;
            for (int w = 0; w < 50; w++) begin
                @(negedge mclk);
                if (bus_req && per_addr == A_HI) begin ok = 1; break; end
            end
        end
        chk("reach_rd_hi", ok, 1);
        #2;
        puc_rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {cmd_ready, res_valid, res_data, res_count, busy, bus_req,
                                  per_addr, per_din, per_en, per_we}, 0);
        @(posedge mclk); @(posedge mclk); #1;
        puc_rst_n = 1'b1;
        q_op1.delete(); q_op2.delete(); set_pair(16'd2, 16'd2);
        run_job(1'b0, 0, 0);
        chk("post_reset_2x2", last_res, 48'h0000_0000_0004);

        // Randomized jobs
        for (int j = 0; j < 25; j++) begin
            gnt_mode = $urandom_range(1, 0);
            q_op1.delete(); q_op2.delete();
            n = $urandom_range(6, 1);
            for (int i = 0; i < n; i++) set_pair(rnd_op(), rnd_op());
            sg = 1'($urandom);
            run_job(sg, 3, $urandom_range(3, 0));
        end

        // Pair counter saturation
        gnt_mode = 1;
        q_op1.delete(); q_op2.delete();
        for (int i = 0; i < 260; i++) set_pair(rnd_op(), rnd_op());
        run_job(1'b1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
